// File: rtl/and_checker_pkg.sv
// and_checker_pkg: shared state type and default parameters for the AND checker
package and_checker_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} chk_state_t;
    localparam int WIDTH_DEF   = 8;
    localparam int ERR_MAX_DEF = 255;
endpackage

// File: rtl/and_checker_sat_cnt.sv
// sat_cnt: saturating up-counter with synchronous clear
module sat_cnt #(
    parameter int W   = 8,
    parameter int MAX = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = clr ? '0 : (inc && cnt_q != W'(MAX)) ? cnt_q + W'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/and_checker.sv
// and_checker: checks c == a & b over a run of num_txn handshaked transactions
module and_checker
    import and_checker_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int ERR_MAX = ERR_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      num_txn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_cnt,
    output logic [15:0]      txn_cnt,
    output logic             first_err_vld,
    output logic [WIDTH-1:0] first_a,
    output logic [WIDTH-1:0] first_b,
    output logic [WIDTH-1:0] first_c
);
    chk_state_t       state_d, state_q;
    logic [15:0]      num_d, num_q, txn_d, txn_q;
    logic             cmp_vld_d, cmp_vld_q, fvld_d, fvld_q;
    logic [WIDTH-1:0] cmp_a_d, cmp_a_q, cmp_b_d, cmp_b_q, cmp_c_d, cmp_c_q;
    logic [WIDTH-1:0] fa_d, fa_q, fb_d, fb_q, fc_d, fc_q;
    logic             start_acc, accept, last_acc, mismatch, capture;

    always_comb begin
        start_acc = start && (state_q == IDLE || state_q == DONE);
        accept    = in_valid && state_q == RUN;
        last_acc  = accept && (txn_q + 16'd1 == num_q);
        mismatch  = cmp_vld_q && (cmp_c_q != (cmp_a_q & cmp_b_q));
        capture   = mismatch && !fvld_q;
        state_d   = start_acc ? ((num_txn == 16'd0) ? DONE : RUN) :
                    last_acc ? DRAIN :
                    (state_q == DRAIN) ? DONE : state_q;
        num_d     = start_acc ? num_txn : num_q;
        txn_d     = start_acc ? 16'd0 : accept ? txn_q + 16'd1 : txn_q;
        cmp_vld_d = accept;
        cmp_a_d   = accept ? a : cmp_a_q;
        cmp_b_d   = accept ? b : cmp_b_q;
        cmp_c_d   = accept ? c : cmp_c_q;
        // only the first mismatch of a run is kept; start re-arms capture
        fvld_d    = start_acc ? 1'b0 : (fvld_q || mismatch);
        fa_d      = capture ? cmp_a_q : fa_q;
        fb_d      = capture ? cmp_b_q : fb_q;
        fc_d      = capture ? cmp_c_q : fc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            num_q     <= '0;
            txn_q     <= '0;
            cmp_vld_q <= 1'b0;
            cmp_a_q   <= '0;
            cmp_b_q   <= '0;
            cmp_c_q   <= '0;
            fvld_q    <= 1'b0;
            fa_q      <= '0;
            fb_q      <= '0;
            fc_q      <= '0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            txn_q     <= txn_d;
            cmp_vld_q <= cmp_vld_d;
            cmp_a_q   <= cmp_a_d;
            cmp_b_q   <= cmp_b_d;
            cmp_c_q   <= cmp_c_d;
            fvld_q    <= fvld_d;
            fa_q      <= fa_d;
            fb_q      <= fb_d;
            fc_q      <= fc_d;
        end
    end

    sat_cnt #(.W(8), .MAX(ERR_MAX)) u_err (
        .clk (clk),
        .rst (rst),
        .clr (start_acc),
        .inc (mismatch),
        .cnt (err_cnt)
    );

    assign in_ready      = state_q == RUN;
    assign busy          = state_q == RUN || state_q == DRAIN;
    assign done          = state_q == DONE;
    assign pass          = done && err_cnt == 8'd0;
    assign txn_cnt       = txn_q;
    assign first_err_vld = fvld_q;
    assign first_a       = fa_q;
    assign first_b       = fb_q;
    assign first_c       = fc_q;
endmodule

// File: tb/tb_and_checker.sv
// tb_and_checker: directed self-checking bench for and_checker
module tb_and_checker;
    import and_checker_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
    logic [15:0] num_txn = '0;
    logic [7:0]  a = '0, b = '0, c = '0;
    logic        in_ready, busy, done, pass, first_err_vld;
    logic [7:0]  err_cnt, first_a, first_b, first_c;
    logic [15:0] txn_cnt;
    int          tests = 0, fails = 0;

    and_checker dut (
        .clk(clk), .rst(rst), .start(start), .num_txn(num_txn),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .c(c),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .txn_cnt(txn_cnt), .first_err_vld(first_err_vld),
        .first_a(first_a), .first_b(first_b), .first_c(first_c)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [15:0] n);
        start = 1'b1;
        num_txn = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] tc);
        in_valid = 1'b1;
        a = ta;
        b = tb_;
        c = tc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        tests++;
        if ({in_ready, busy, done, pass, err_cnt, txn_cnt, first_err_vld, first_a, first_b, first_c} !== '0) begin
            $display("FAIL reset_outputs got %h required 0", {in_ready, busy, done, pass, err_cnt, txn_cnt, first_err_vld, first_a, first_b, first_c});
            fails++;
        end
        tick();
        rst = 1'b0;
        tick();
        tests++;
        if (dut.state_q !== IDLE || {busy, done, in_ready} !== 3'b000) begin
            $display("FAIL reset_idle got state %0d busy/done/rdy %b required IDLE 000", dut.state_q, {busy, done, in_ready});
            fails++;
        end
    endtask

    task automatic test_basic;
        start_run(16'd4);
        tests++;
        if ({busy, in_ready, done} !== 3'b110) begin
            $display("FAIL basic_run got busy/rdy/done %b required 110", {busy, in_ready, done});
            fails++;
        end
        repeat (4) send(8'hF0, 8'h3C, 8'h30);
        tests++;
        if ({busy, in_ready, done} !== 3'b100 || dut.state_q !== DRAIN) begin
            $display("FAIL basic_drain got busy/rdy/done %b state %0d required 100 DRAIN", {busy, in_ready, done}, dut.state_q);
            fails++;
        end
        tick();
        tests++;
        if ({busy, done, pass, err_cnt, txn_cnt} !== {3'b011, 8'd0, 16'd4}) begin
            $display("FAIL basic_done got busy/done/pass %b err %0d txn %0d required 011 0 4", {busy, done, pass}, err_cnt, txn_cnt);
            fails++;
        end
        repeat (3) tick();
        tests++;
        if ({done, pass} !== 2'b11) begin
            $display("FAIL basic_hold got done/pass %b required 11", {done, pass});
            fails++;
        end
    endtask

    task automatic test_first_err;
        start_run(16'd3);
        send(8'hF0, 8'h3C, 8'h30);
        send(8'hFF, 8'h0F, 8'h1F);
        send(8'hAA, 8'h55, 8'h00);
        tick();
        tests++;
        if ({done, pass, err_cnt, txn_cnt} !== {2'b10, 8'd1, 16'd3}) begin
            $display("FAIL first_err_counts got done/pass %b err %0d txn %0d required 10 1 3", {done, pass}, err_cnt, txn_cnt);
            fails++;
        end
        tests++;
        if ({first_err_vld, first_a, first_b, first_c} !== {1'b1, 8'hFF, 8'h0F, 8'h1F}) begin
            $display("FAIL first_err_capture got %b %h %h %h required 1 ff 0f 1f", first_err_vld, first_a, first_b, first_c);
            fails++;
        end
    endtask

    task automatic test_saturate;
        logic [31:0] iv;
        start_run(16'd300);
        for (int i = 0; i < 300; i++) begin
            iv = 32'(i);
            send(iv[7:0], 8'hFF, ~iv[7:0]);
            if (i < 2) begin
                tests++;
                if (err_cnt !== 8'(i)) begin
                    $display("FAIL sat_latency_%0d got err %0d required %0d", i, err_cnt, i);
                    fails++;
                end
            end
        end
        tick();
        tests++;
        if ({done, pass, err_cnt, txn_cnt} !== {2'b10, 8'd255, 16'd300}) begin
            $display("FAIL sat_counts got done/pass %b err %0d txn %0d required 10 255 300", {done, pass}, err_cnt, txn_cnt);
            fails++;
        end
        tests++;
        if ({first_err_vld, first_a, first_b, first_c} !== {1'b1, 8'h00, 8'hFF, 8'hFF}) begin
            $display("FAIL sat_first got %b %h %h %h required 1 00 ff ff", first_err_vld, first_a, first_b, first_c);
            fails++;
        end
    endtask

    task automatic test_zero;
        logic seen = 1'b0;
        start_run(16'd0);
        tests++;
        if ({done, pass, in_ready, first_err_vld, err_cnt, txn_cnt} !== {4'b1100, 8'd0, 16'd0}) begin
            $display("FAIL zero_done got done/pass/rdy/fvld %b err %0d txn %0d required 1100 0 0", {done, pass, in_ready, first_err_vld}, err_cnt, txn_cnt);
            fails++;
        end
        for (int i = 0; i < 5; i++) begin
            seen |= in_ready;
            tick();
        end
        tests++;
        if (seen !== 1'b0 || done !== 1'b1) begin
            $display("FAIL zero_ready got rdy_seen %b done %b required 0 1", seen, done);
            fails++;
        end
    endtask

    task automatic test_reset_mid;
        start_run(16'd5);
        send(8'h0F, 8'h0F, 8'h0F);
        send(8'h0F, 8'h0F, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({in_ready, busy, done, pass, err_cnt, txn_cnt, first_err_vld, first_a, first_b, first_c} !== '0 || dut.state_q !== IDLE) begin
            $display("FAIL rstmid_async got %h state %0d required 0 IDLE", {in_ready, busy, done, pass, err_cnt, txn_cnt, first_err_vld, first_a, first_b, first_c}, dut.state_q);
            fails++;
        end
        tick();
        rst = 1'b0;
        tick();
        tests++;
        if ({err_cnt, first_err_vld, done, pass} !== '0) begin
            $display("FAIL rstmid_discard got err %0d fvld %b done/pass %b required 0 0 00", err_cnt, first_err_vld, {done, pass});
            fails++;
        end
        start_run(16'd1);
        send(8'h33, 8'h0F, 8'h03);
        tick();
        tests++;
        if ({done, pass, err_cnt, txn_cnt} !== {2'b11, 8'd0, 16'd1}) begin
            $display("FAIL rstmid_rerun got done/pass %b err %0d txn %0d required 11 0 1", {done, pass}, err_cnt, txn_cnt);
            fails++;
        end
    endtask

    task automatic test_random_valid;
        int hs = 0, cyc = 0;
        start_run(16'd6);
        while (hs < 6 && cyc < 200) begin
            in_valid = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            b = 8'($urandom);
            c = a & b;
            start = (cyc % 3 == 0);
            num_txn = 16'd2;
            if (in_valid && in_ready) hs++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (hs != 6 || {done, pass, err_cnt, txn_cnt} !== {2'b11, 8'd0, 16'd6}) begin
            $display("FAIL random_valid got hs %0d done/pass %b err %0d txn %0d required 6 11 0 6", hs, {done, pass}, err_cnt, txn_cnt);
            fails++;
        end
    endtask

    task automatic test_max;
        logic [31:0] iv;
        start_run(16'hFFFF);
        for (int i = 0; i < 65535; i++) begin
            iv = 32'(i);
            send(iv[7:0], 8'hA5, iv[7:0] & 8'hA5);
        end
        tick();
        tests++;
        if ({done, pass, err_cnt, txn_cnt} !== {2'b11, 8'd0, 16'hFFFF}) begin
            $display("FAIL max_txn got done/pass %b err %0d txn %h required 11 0 ffff", {done, pass}, err_cnt, txn_cnt);
            fails++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_first_err();
        test_saturate();
        test_zero();
        test_reset_mid();
        test_random_valid();
        test_max();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
